// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare direction predictor.
//   bp_state_e       : table-init / run state encoding
//   sat_inc/sat_dec  : saturating counter successor for a given counter width
//   ctr_init_default : weakly-not-taken counter value for a given width
package bp_pkg;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // Largest value representable in w bits (w in 1..32).
  function automatic logic [31:0] ctr_max(input int unsigned w);
    return (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return (v >= ctr_max(w)) ? ctr_max(w) : (v + 32'd1);
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v, input int unsigned w);
    return (v == 32'd0) ? 32'd0 : (v - 32'd1);
  endfunction

  // 2**(w-1)-1: the highest value whose MSB is still clear.
  function automatic int unsigned ctr_init_default(input int unsigned w);
    return int'((32'd1 << (w - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Lookup (IF side) and resolve/update (EX side) bundle of the gshare predictor.
//   master : the core pipeline; drives lookup_* and update_*, observes predictions
//   slave  : the predictor; returns pred_*, ready
interface gshare_predictor_if #(
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned GHR_WIDTH = 10
);

  logic                 lookup_valid;
  logic [31:0]          lookup_pc;
  logic                 pred_taken;
  logic [CTR_WIDTH-1:0] pred_state;
  logic [GHR_WIDTH-1:0] pred_ghr;
  logic                 ready;
  logic                 update_valid;
  logic [31:0]          update_pc;
  logic [GHR_WIDTH-1:0] update_ghr;
  logic [CTR_WIDTH-1:0] update_state;
  logic                 update_taken;
  logic                 mispredict;

  modport master (
    output lookup_valid, lookup_pc,
    output update_valid, update_pc, update_ghr, update_state, update_taken, mispredict,
    input  pred_taken, pred_state, pred_ghr, ready
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_ghr, update_state, update_taken, mispredict,
    output pred_taken, pred_state, pred_ghr, ready
  );

endinterface

// File: rtl/pht_array.sv
// Pattern history table storage: 2**S_INDEX counters of CTR_WIDTH bits.
//   clk     : write clock
//   wr_en   : write strobe, wr_data lands in wr_idx at the next edge
//   rd_idx  : asynchronous read address, rd_data returns the stored counter
// No reset: contents are established by the predictor's init sweep.
module pht_array #(
  parameter int unsigned S_INDEX   = 10,
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [S_INDEX-1:0]   wr_idx,
  input  logic [CTR_WIDTH-1:0] wr_data,
  input  logic [S_INDEX-1:0]   rd_idx,
  output logic [CTR_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << S_INDEX;

  logic [CTR_WIDTH-1:0] mem [0:DEPTH-1];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Asynchronous read; a same-cycle write is not forwarded.
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/gshare_predictor.sv
// gshare branch direction predictor: table of saturating counters indexed by
// PC[S_INDEX+1:2] XOR a speculative global history register.
//   clk, rst : clock and synchronous active-high reset
//   bp       : lookup/prediction and update/recovery bundle (slave side)
// After reset the table is swept to CTR_INIT over 2**S_INDEX cycles; ready
// rises once the sweep is done and predictions are forced not-taken before.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned S_INDEX   = 10,
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned GHR_WIDTH = 10,
  parameter int unsigned CTR_INIT  = ctr_init_default(CTR_WIDTH)
) (
  input logic               clk,
  input logic               rst,
  gshare_predictor_if.slave bp
);

  localparam logic [S_INDEX-1:0] LAST_IDX = '1;

  bp_state_e            state;
  bp_state_e            state_nxt;
  logic [S_INDEX-1:0]   init_idx;
  logic [S_INDEX-1:0]   init_idx_nxt;
  logic [GHR_WIDTH-1:0] ghr;
  logic [GHR_WIDTH-1:0] ghr_nxt;
  logic [S_INDEX-1:0]   lookup_idx;
  logic [S_INDEX-1:0]   update_idx;
  logic [S_INDEX-1:0]   wr_idx;
  logic [CTR_WIDTH-1:0] wr_ctr;
  logic [CTR_WIDTH-1:0] upd_ctr;
  logic [CTR_WIDTH-1:0] rd_ctr;
  logic                 wr_en;
  logic                 run;
  logic                 pred_taken;
  logic                 unused_pc_bits;

  assign run = (state == BP_RUN);

  // Index hashing: word-aligned PC bits XOR zero-extended history.
  assign lookup_idx = bp.lookup_pc[S_INDEX+1:2] ^ S_INDEX'(ghr);
  assign update_idx = bp.update_pc[S_INDEX+1:2] ^ S_INDEX'(bp.update_ghr);

  // Successor of the counter value carried down the pipe, not a table re-read.
  assign upd_ctr = bp.update_taken ? CTR_WIDTH'(sat_inc(32'(bp.update_state), CTR_WIDTH))
                                   : CTR_WIDTH'(sat_dec(32'(bp.update_state), CTR_WIDTH));

  // State and sweep-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BP_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  // Next state and table write port selection.
  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    wr_en        = 1'b0;
    wr_idx       = update_idx;
    wr_ctr       = upd_ctr;
    unique case (state)
      BP_INIT: begin
        wr_en        = 1'b1;
        wr_idx       = init_idx;
        wr_ctr       = CTR_WIDTH'(CTR_INIT);
        init_idx_nxt = init_idx + S_INDEX'(1);
        if (init_idx == LAST_IDX) begin
          state_nxt = BP_RUN;
        end
      end
      BP_RUN: begin
        wr_en = bp.update_valid;
      end
      default: begin
        state_nxt = BP_INIT;
      end
    endcase
    // A write in the reset cycle is pointless: the sweep rewrites everything.
    if (rst) begin
      wr_en = 1'b0;
    end
  end

  // History update: mispredict recovery beats the speculative lookup shift.
  // The width cast drops the oldest bit, which also covers GHR_WIDTH == 1.
  always_comb begin
    ghr_nxt = ghr;
    if (run && bp.update_valid && bp.mispredict) begin
      ghr_nxt = GHR_WIDTH'({bp.update_ghr, bp.update_taken});
    end else if (run && bp.lookup_valid) begin
      ghr_nxt = GHR_WIDTH'({ghr, pred_taken});
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_nxt;
    end
  end

  pht_array #(
    .S_INDEX   (S_INDEX),
    .CTR_WIDTH (CTR_WIDTH)
  ) u_pht (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_ctr),
    .rd_idx  (lookup_idx),
    .rd_data (rd_ctr)
  );

  assign pred_taken    = run & rd_ctr[CTR_WIDTH-1];
  assign bp.pred_taken = pred_taken;
  assign bp.pred_state = rd_ctr;
  assign bp.pred_ghr   = ghr;
  assign bp.ready      = run;

  // PC bits outside the index field do not affect the prediction.
  assign unused_pc_bits = ^{bp.lookup_pc[31:S_INDEX+2], bp.lookup_pc[1:0],
                            bp.update_pc[31:S_INDEX+2], bp.update_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor (S_INDEX=4, CTR_WIDTH=2,
// GHR_WIDTH=4, CTR_INIT=1). Inputs change 1 time unit after the rising edge;
// combinational outputs are sampled 1 time unit after inputs settle.
module tb_gshare_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  // Saturation vectors: update_state sent, direction, counter value written.
  int sat_in  [7] = '{1, 2, 3, 3, 2, 1, 0};
  int sat_tk  [7] = '{1, 1, 1, 0, 0, 0, 0};
  int sat_exp [7] = '{2, 3, 3, 2, 1, 0, 0};

  // History vectors: lookup PC, GHR seen, expected prediction.
  logic [31:0] hist_pc    [4] = '{32'h14, 32'h04, 32'h1C, 32'h00};
  int          hist_ghr   [4] = '{0, 1, 2, 5};
  int          hist_taken [4] = '{1, 0, 1, 1};

  always #5 clk = ~clk;

  gshare_predictor_if #(.CTR_WIDTH(2), .GHR_WIDTH(4)) bp_if ();

  gshare_predictor #(
    .S_INDEX   (4),
    .CTR_WIDTH (2),
    .GHR_WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_if.lookup_valid = 1'b0;
    bp_if.update_valid = 1'b0;
    bp_if.mispredict   = 1'b0;
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic [3:0] ghr,
                              input logic [1:0] st, input logic taken, input logic misp);
    bp_if.update_valid = 1'b1;
    bp_if.update_pc    = pc;
    bp_if.update_ghr   = ghr;
    bp_if.update_state = st;
    bp_if.update_taken = taken;
    bp_if.mispredict   = misp;
  endtask

  // One-cycle non-mispredicted update, then idle.
  task automatic train(input logic [31:0] pc, input logic [3:0] ghr,
                       input logic [1:0] st, input logic taken);
    drive_update(pc, ghr, st, taken, 1'b0);
    tick();
    idle();
  endtask

  task automatic read_entry(input string tag, input logic [31:0] pc, input logic [1:0] exp);
    bp_if.lookup_pc = pc;
    #1;
    check(tag, 32'(bp_if.pred_state), 32'(exp));
  endtask

  // 16-cycle init sweep; a stray update/mispredict/lookup in its last cycle must be ignored.
  task automatic init_sweep(input string tag, input logic [31:0] stray_pc);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_ready_low"}, 32'(bp_if.ready), 32'd0);
      check({tag, "_taken_low"}, 32'(bp_if.pred_taken), 32'd0);
      if (i == 15) begin
        drive_update(stray_pc, 4'h0, 2'd2, 1'b1, 1'b1);
        bp_if.lookup_valid = 1'b1;
      end
      tick();
    end
    idle();
    #1;
    check({tag, "_ready_high"}, 32'(bp_if.ready), 32'd1);
    check({tag, "_ghr_held"}, 32'(bp_if.pred_ghr), 32'd0);
    for (int e = 0; e < 16; e++) begin
      read_entry({tag, "_entry_init"}, 32'(e) << 2, 2'd1);
      check({tag, "_entry_nt"}, 32'(bp_if.pred_taken), 32'd0);
    end
  endtask

  initial begin
    idle();
    bp_if.lookup_pc    = 32'h0;
    bp_if.update_pc    = 32'h0;
    bp_if.update_ghr   = 4'h0;
    bp_if.update_state = 2'd0;
    bp_if.update_taken = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_ready", 32'(bp_if.ready), 32'd0);
    check("rst_taken", 32'(bp_if.pred_taken), 32'd0);
    check("rst_ghr", 32'(bp_if.pred_ghr), 32'd0);
    rst = 1'b0;
    init_sweep("init", 32'h0);

    // Saturation on entry 0 with history frozen; old value visible until the edge.
    bp_if.lookup_pc = 32'h40;
    for (int k = 0; k < 7; k++) begin
      drive_update(32'h40, 4'h0, 2'(sat_in[k]), 1'(sat_tk[k]), 1'b0);
      #1;
      check("sat_no_bypass", 32'(bp_if.pred_state), 32'(sat_in[k]));
      tick();
      idle();
      #1;
      check("sat_state", 32'(bp_if.pred_state), 32'(sat_exp[k]));
      check("sat_taken", 32'(bp_if.pred_taken), 32'(sat_exp[k] >> 1));
    end
    check("sat_ghr_frozen", 32'(bp_if.pred_ghr), 32'd0);

    // Make entry 5 taken, then shift T,N,T,T into the history.
    train(32'h14, 4'h0, 2'd1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bp_if.lookup_pc    = hist_pc[k];
      bp_if.lookup_valid = 1'b1;
      #1;
      check("hist_ghr", 32'(bp_if.pred_ghr), 32'(hist_ghr[k]));
      check("hist_taken", 32'(bp_if.pred_taken), 32'(hist_taken[k]));
      tick();
      idle();
    end
    #1;
    check("hist_final", 32'(bp_if.pred_ghr), 32'hB);

    // Recovery wins over a same-cycle lookup shift.
    bp_if.lookup_pc    = 32'h14;
    bp_if.lookup_valid = 1'b1;
    drive_update(32'h3C, 4'b0010, 2'd1, 1'b1, 1'b1);
    tick();
    idle();
    #1;
    check("recover_ghr", 32'(bp_if.pred_ghr), 32'h5);
    read_entry("recover_write", 32'h20, 2'd2);

    // Mispredict without update_valid is ignored.
    bp_if.mispredict = 1'b1;
    tick();
    idle();
    check("misp_unqualified", 32'(bp_if.pred_ghr), 32'h5);

    // Recover to zero history, then alias pc=0x10/GHR=0 with pc=0x14/GHR=1.
    drive_update(32'h3C, 4'h0, 2'd1, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    check("recover_zero", 32'(bp_if.pred_ghr), 32'h0);
    read_entry("alias_before", 32'h10, 2'd1);
    train(32'h14, 4'h1, 2'd1, 1'b1);
    read_entry("alias_after", 32'h10, 2'd2);
    check("alias_taken", 32'(bp_if.pred_taken), 32'd1);

    // Train entry 3 to 3, shift a taken bit in, then reset mid-run.
    train(32'h0C, 4'h0, 2'd2, 1'b1);
    read_entry("e3_trained", 32'h0C, 2'd3);
    bp_if.lookup_valid = 1'b1;
    tick();
    idle();
    #1;
    check("pre_rst_ghr", 32'(bp_if.pred_ghr), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rerst_ghr", 32'(bp_if.pred_ghr), 32'd0);
    init_sweep("reinit", 32'h0C);
    read_entry("e3_reinit", 32'h0C, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the per-PC 2-bit branch history table: a gshare direction predictor.
- Indexes a table of N-bit saturating counters with the fetch PC XOR a speculative global history register (GHR).
- Sits beside IF (lookup) and EX (resolve/update).
- Adds hardware table initialisation after reset, configurable counter width, and GHR recovery on mispredict.

Parameters:
- S_INDEX, 10, log2 of table entries.
- CTR_WIDTH, 2, counter width in bits (>=1).
- GHR_WIDTH, 10, global history length (1..S_INDEX).
- CTR_INIT, 2**(CTR_WIDTH-1)-1, counter value written at init (weakly not-taken).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- lookup_valid  in  1  IF presents a fetch PC this cycle.
- lookup_pc  in  32  fetch PC.
- pred_taken  out  1  predicted direction (combinational from lookup_pc and GHR).
- pred_state  out  CTR_WIDTH  counter value read; carried down the pipe.
- pred_ghr  out  GHR_WIDTH  GHR snapshot used for this lookup; carried down the pipe.
- ready  out  1  table initialised; predictions valid.
- update_valid  in  1  EX resolves a branch or jump this cycle.
- update_pc  in  32  PC of the resolving instruction.
- update_ghr  in  GHR_WIDTH  pred_ghr snapshot carried with that instruction.
- update_state  in  CTR_WIDTH  pred_state carried with that instruction.
- update_taken  in  1  actual outcome (br_en | jump).
- mispredict  in  1  EX direction mismatch; qualified by update_valid.

Behaviour:
- Index rules:
  - Lookup index = lookup_pc[S_INDEX+1:2] XOR zero-extended GHR.
  - Write index = update_pc[S_INDEX+1:2] XOR zero-extended update_ghr.
- Read path:
  - Table read is asynchronous.
  - pred_taken = ready & counter MSB.
  - pred_state = counter value.
  - pred_ghr = current GHR.
- Counter write:
  - Occurs only when state is RUN and update_valid=1.
  - Writes the saturating successor of update_state, not a re-read of the table.
  - Taken: min(update_state+1, 2**CTR_WIDTH-1).
  - Not taken: max(update_state-1, 0).
  - Written the following cycle edge.
- Read-during-write to the same index: lookup returns the old value; no bypass.
- GHR update, in priority order:
  1. rst: GHR <= 0.
  2. RUN & update_valid & mispredict: GHR <= {update_ghr[GHR_WIDTH-2:0], update_taken}. Recovery overrides any same-cycle lookup shift.
  3. RUN & lookup_valid: GHR <= {GHR[GHR_WIDTH-2:0], pred_taken}.
  4. Otherwise hold.
  - With GHR_WIDTH=1, the shifted value is just the new bit.
- FSM states: INIT, RUN.
  - rst forces INIT and resets init_idx to 0.
  - In INIT, each cycle writes CTR_INIT to entry init_idx, then increments init_idx.
  - When init_idx == 2**S_INDEX-1, the write completes and the next state is RUN.
  - INIT lasts exactly 2**S_INDEX cycles after rst deasserts.
  - In INIT: ready=0, pred_taken=0, update_valid ignored, GHR held at 0.
  - rst asserted mid-INIT or mid-RUN restarts INIT from index 0.
- Reset values: ready=0, pred_taken=0, GHR=0, so pred_ghr=0. pred_state is don't-care until ready.
- No stall handshake. The core must not rely on predictions while ready=0; the default is not-taken.

Decomposition:
- Package bp_pkg holds:
  - enum bp_state_e {BP_INIT, BP_RUN};
  - functions sat_inc and sat_dec, parametrised by width;
  - the default CTR_INIT expression.
- One sub-module, pht_array (S_INDEX, CTR_WIDTH):
  - async read port, synchronous write port;
  - no initial block; contents come from the INIT sweep.
- FSM, GHR and index hashing live in gshare_predictor.

Test Plan:
- Init: S_INDEX=4, pulse rst for 1 cycle -> ready=0 for exactly 16 cycles, then 1; every entry reads CTR_INIT=1; pred_taken=0.
- Saturation: with GHR frozen (lookup_valid=0), pc=0x40, send 3 updates taken with update_state chained 1->2->3 -> written values 2,3,3; then 4 not-taken -> 2,1,0,0; pred_taken follows the MSB.
- History shift: GHR_WIDTH=4, lookups with predictions T,N,T,T -> GHR=4'b1011; pred_ghr on the next lookup equals 4'b1011.
- Recovery priority: same cycle lookup_valid=1 and update_valid=1, mispredict=1, update_ghr=4'b0010, update_taken=1 -> GHR=4'b0101, not the shifted speculative value.
- Aliasing/hash: pc=0x10 with GHR=0 and pc=0x14 with GHR=1 map to the same index; training one changes the other's pred_state.
- Reset mid-RUN: after training entry 3 to 3, assert rst -> ready=0, GHR=0, INIT re-sweeps, and entry 3 reads CTR_INIT afterward; updates during INIT leave the table unchanged.
